mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the five-stage pipeline. Sits between the pipeline stages and the memory macro, serialises accesses with a fixed wait-state count and returns per-requester ready pulses. Drives stall signals that the top level ORs into the PC/IF_ID write-enable and the EXE_MEM hold path.

## Interface
- WAIT_CYCLES, 1, memory access cycles per transfer (legal 1..15)
- Clk  in  1  clock, rising edge
- Clrn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction, valid while if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ready
- d_ready  out  1  one-cycle data completion pulse
- stall_if  out  1  if_req & ~if_ready
- stall_d  out  1  d_req & ~d_ready
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr, mem_wdata  out  32  memory address / write data
- mem_rdata  in  32  memory read data, valid in last BUSY cycle

## Operation
- FSM states IDLE, BUSY, DONE; grant register gnt (0 = IF, 1 = D); wait counter cnt (4 bits).
- IDLE: if any req, latch winner's addr/we/wdata into request register, set gnt, cnt<=0, go BUSY; else stay.
- Tie (both req in IDLE): D wins (see Configuration).
- BUSY: mem_en=1, mem_we=latched we (0 for IF), mem_addr/mem_wdata from latch; cnt increments; when cnt==WAIT_CYCLES-1, capture mem_rdata into winner's rdata register, go DONE.
- DONE: winner's ready=1 for exactly one cycle; mem_en=0; go IDLE. Requests seen in DONE are not granted.
- Stores: d_ready pulses; d_rdata keeps previous value.
- Loser's request stays pending; it is granted on next IDLE cycle.
- Requester drops req in cycle after ready unless issuing a new request; a req still high in IDLE is a new request.
- Outside BUSY: mem_en=0, mem_we=0, mem_addr/mem_wdata=latched values.

## Timing
- Reset (async): state=IDLE, gnt=0, cnt=0, last-grant=D, latches 0, if_rdata=d_rdata=0, if_ready=d_ready=0, mem_en=mem_we=0, mem_addr=mem_wdata=0.
- Latency: req high in IDLE cycle T -> BUSY cycles T+1..T+WAIT_CYCLES -> ready high cycle T+WAIT_CYCLES+1.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- stall_if/stall_d combinational from req and ready; no registered delay.
- Reset mid-BUSY: mem_we drops immediately; in-flight access abandoned, no ready pulse.
- if_ready and d_ready never high in the same cycle.

## Configuration
- ARB_RR_EN defined: tie resolved round-robin via last-grant flag (grant the requester not granted last; flag updated on every grant; reset value D so first tie goes to IF).
- Undefined: fixed priority, D always wins ties; last-grant flag not built.

## Structure
- Package pipe_arb_pkg: state enum (ARB_IDLE, ARB_BUSY, ARB_DONE), grant encoding (GNT_IF, GNT_D), WAIT_CYCLES_MAX=15.
- One sub-module: arb_wait_cnt (load/increment/terminal-count flag for cnt).

## Test plan
- Reset then if_req, if_addr=0x0000_0004, WAIT_CYCLES=1, mem_rdata=0x2001_0005 -> mem_en cycle 1, if_ready + if_rdata=0x2001_0005 cycle 2, stall_if high cycles 0–1.
- Store d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF, WAIT_CYCLES=3 -> mem_we=1 with those values cycles 1–3, d_ready cycle 4, d_rdata unchanged.
- if_req and d_req both high in IDLE, macro off -> D served first (d_ready cycle 2), IF granted cycle 3, if_ready cycle 5.
- Same tie with ARB_RR_EN, two consecutive ties -> first IF, then D; alternate thereafter.
- Clrn low during BUSY of a store -> mem_we/mem_en 0 immediately, no d_ready, state IDLE after release.
- Continuous if_req with WAIT_CYCLES=2 -> if_ready every 4 cycles, never coincident with d_ready.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, grant encoding, request latch.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_gnt_t;

  localparam int WAIT_CYCLES_MAX = 15;
  localparam int CNT_W           = $clog2(WAIT_CYCLES_MAX + 1);

  // Everything the memory needs for one transfer, captured at grant time.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// Wait-state counter for one memory transfer: cleared on grant, counts BUSY cycles.
// Latency: tc is combinational from the count; count updates on the clock edge.
// Backpressure: none; the arbiter FSM decides when to load and when to increment.
module arb_wait_cnt
  import pipe_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic Clk,
  input  logic Clrn,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Clear on grant, otherwise advance once per BUSY cycle.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Last BUSY cycle of the transfer: memory read data is valid now.
  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF and MEM; define ARB_RR_EN for round-robin ties, else D wins ties.
// Latency: request seen in IDLE -> WAIT_CYCLES BUSY cycles -> one-cycle ready pulse (WAIT_CYCLES+2 per access).
// Backpressure: requesters hold req/addr/data until their ready pulse; stall_* tell the pipeline to hold meanwhile.
module mem_port_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall_if,
  output logic        stall_d,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t state, state_nxt;
  arb_gnt_t   gnt, gnt_nxt;
  arb_gnt_t   winner;
  mem_req_t   lat, lat_nxt;
  logic       grant;
  logic       capture;
  logic       cnt_load;
  logic       cnt_inc;
  logic       cnt_tc;

`ifdef ARB_RR_EN
  arb_gnt_t   last_gnt;
`endif

  arb_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .Clk  (Clk),
    .Clrn (Clrn),
    .load (cnt_load),
    .inc  (cnt_inc),
    .tc   (cnt_tc)
  );

  // Pick who would be granted this cycle if the port is idle.
  always_comb begin
    winner = GNT_IF;
    if (d_req && if_req) begin
`ifdef ARB_RR_EN
      winner = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
`else
      winner = GNT_D;
`endif
    end else if (d_req) begin
      winner = GNT_D;
    end
  end

  // FSM next state, request latch contents, counter control and memory/ready outputs.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    lat_nxt   = lat;
    grant     = 1'b0;
    capture   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          grant     = 1'b1;
          gnt_nxt   = winner;
          cnt_load  = 1'b1;
          state_nxt = ARB_BUSY;
          if (winner == GNT_D) begin
            lat_nxt.we    = d_we;
            lat_nxt.addr  = d_addr;
            lat_nxt.wdata = d_wdata;
          end else begin
            // Fetches never write; the write-data latch is cleared so the bus idles at zero.
            lat_nxt.we    = 1'b0;
            lat_nxt.addr  = if_addr;
            lat_nxt.wdata = '0;
          end
        end
      end
      ARB_BUSY: begin
        mem_en  = 1'b1;
        mem_we  = lat.we;
        cnt_inc = 1'b1;
        if (cnt_tc) begin
          capture   = 1'b1;
          state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        // Requests are deliberately ignored here so the winner can drop its req first.
        if_ready  = (gnt == GNT_IF);
        d_ready   = (gnt == GNT_D);
        state_nxt = ARB_IDLE;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State, grant and request latch registers.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= ARB_IDLE;
      gnt   <= GNT_IF;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      lat   <= lat_nxt;
    end
  end

  // Capture read data on the last BUSY cycle; stores leave d_rdata untouched.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (capture) begin
      if (gnt == GNT_IF) begin
        if_rdata <= mem_rdata;
      end else if (!lat.we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

`ifdef ARB_RR_EN
  // Remember the most recent grant so the next tie goes to the other requester.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      last_gnt <= GNT_D;
    end else if (grant) begin
      last_gnt <= winner;
    end
  end
`endif

  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;
  assign stall_if  = if_req & ~if_ready;
  assign stall_d   = d_req & ~d_ready;

endmodule
